// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver.
// One-hot FSM encoding, parity modes and a majority helper.
package uart_pkg;

  localparam int I_IDLE  = 0;
  localparam int I_START = 1;
  localparam int I_DATA  = 2;
  localparam int I_PAR   = 3;
  localparam int I_STOP  = 4;

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_START = 5'b00010;
  localparam logic [4:0] S_DATA  = 5'b00100;
  localparam logic [4:0] S_PAR   = 5'b01000;
  localparam logic [4:0] S_STOP  = 5'b10000;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, oversample tick counter and 3-sample vote.
// Emits a decision strobe mid-bit and a bit-end strobe.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_tick,
  input  logic i_rx,
  input  logic i_run,
  output logic o_rx_s,
  output logic o_bit,
  output logic o_dec,
  output logic o_end
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;

  logic [1:0]    sync_q;
  logic [TW-1:0] t_q, t_d;
  logic          s0_q, s1_q;
  logic          tk;

  assign o_rx_s = sync_q[1];
  assign tk     = i_run & i_tick;

  // Counter is pinned at zero while idle so a start edge begins at t=0.
  always_comb begin
    t_d = t_q;
    if (!i_run) begin
      t_d = '0;
    end else if (i_tick) begin
      t_d = (t_q == TW'(OVERSAMPLE-1)) ? '0 : t_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q <= 2'b11;
      t_q    <= '0;
      s0_q   <= 1'b1;
      s1_q   <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], i_rx};
      t_q    <= t_d;
      if (tk && t_q == TW'(M-1)) s0_q <= o_rx_s;
      if (tk && t_q == TW'(M))   s1_q <= o_rx_s;
    end
  end

  assign o_bit = maj3(s0_q, s1_q, o_rx_s);
  assign o_dec = tk && (t_q == TW'(M+1));
  assign o_end = tk && (t_q == TW'(OVERSAMPLE-1));

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver: frame FSM, parity/framing checks and a
// valid/ready holding register with sticky overrun.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_tick,
  input  logic                 i_rx,
  input  logic [1:0]           i_parity_mode,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CW = $clog2(DATA_BITS+1);

  logic [4:0]           state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 stop_q, stop_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 commit;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, operr_q, oferr_q, ovr_q;
  logic                 hs;

  logic rx_s, bit_v, dec, bend, run, par_en;

  assign run = ~state_q[I_IDLE];

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_smp (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_tick   (i_tick),
    .i_rx     (i_rx),
    .i_run    (run),
    .o_rx_s   (rx_s),
    .o_bit    (bit_v),
    .o_dec    (dec),
    .o_end    (bend)
  );

  assign par_en = (mode_q == PAR_ODD) || (mode_q == PAR_EVEN);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    commit  = 1'b0;
    unique case (1'b1)
      state_q[I_IDLE]: begin
        if (!rx_s) begin
          state_d = S_START;
          mode_d  = i_parity_mode;
          cnt_d   = '0;
          stop_d  = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      state_q[I_START]: begin
        if (dec && bit_v)  state_d = S_IDLE;
        else if (bend)     state_d = S_DATA;
      end
      state_q[I_DATA]: begin
        if (dec) begin
          shift_d = {bit_v, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + 1'b1;
        end
        if (bend && cnt_q == CW'(DATA_BITS))
          state_d = par_en ? S_PAR : S_STOP;
      end
      state_q[I_PAR]: begin
        if (dec) begin
          perr_d = (mode_q == PAR_ODD) ? ~(^shift_q ^ bit_v)
                                       :  (^shift_q ^ bit_v);
        end
        if (bend) state_d = S_STOP;
      end
      state_q[I_STOP]: begin
        if (dec) begin
          if (!bit_v) ferr_d = 1'b1;
          // Leave mid-bit on the last stop so an early start is seen.
          if (stop_q == 1'(STOP_BITS-1)) begin
            commit  = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= PAR_NONE;
      shift_q <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign hs = valid_q & i_ready;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      operr_q <= 1'b0;
      oferr_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (commit && (!valid_q || i_ready)) begin
        data_q  <= shift_q;
        operr_q <= perr_q;
        oferr_q <= ferr_d;
        valid_q <= 1'b1;
      end else if (hs) begin
        valid_q <= 1'b0;
      end
      if (commit && valid_q && !i_ready) ovr_q <= 1'b1;
      else if (hs)                       ovr_q <= 1'b0;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = operr_q;
  assign o_frame_err  = oferr_q;
  assign o_overrun    = ovr_q;
  assign o_busy       = run;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed plus random frames against a frame-level reference model.
// Two instances: 8-bit/1-stop and 8-bit/2-stop.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx2 = 1'b1;
  logic       ready = 1'b1;
  logic [1:0] pm = 2'd0;
  int         tcnt = 0;

  logic [7:0] d1, d2;
  logic v1, pe1, fe1, ov1, b1;
  logic v2, pe2, fe2, ov2, b2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } word_t;

  word_t q1[$];
  word_t q2[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tcnt <= (tcnt == 2) ? 0 : tcnt + 1;
    tick <= (tcnt == 2);
  end

  uart_rx_param #(.DATA_BITS(8), .STOP_BITS(1), .OVERSAMPLE(16)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_tick(tick), .i_rx(rx),
    .i_parity_mode(pm), .i_ready(ready), .o_data(d1), .o_valid(v1),
    .o_parity_err(pe1), .o_frame_err(fe1), .o_overrun(ov1), .o_busy(b1)
  );

  uart_rx_param #(.DATA_BITS(8), .STOP_BITS(2), .OVERSAMPLE(16)) dut2 (
    .i_clock(clk), .i_reset_n(rst_n), .i_tick(tick), .i_rx(rx2),
    .i_parity_mode(pm), .i_ready(1'b1), .o_data(d2), .o_valid(v2),
    .o_parity_err(pe2), .o_frame_err(fe2), .o_overrun(ov2), .o_busy(b2)
  );

  always @(negedge clk) begin
    if (v1 && ready) q1.push_back(word_t'({d1, pe1, fe1}));
    if (v2)          q2.push_back(word_t'({d2, pe2, fe2}));
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!tick);
    end
    #1;
  endtask

  task automatic set_line(input logic sel, input logic v);
    if (sel) rx2 = v;
    else     rx  = v;
  endtask

  task automatic send(input logic sel, input logic [7:0] d,
                      input logic use_par, input logic pbit,
                      input logic [1:0] stops, input int nstop,
                      input int gbit);
    set_line(sel, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      if (i == gbit) begin
        wait_ticks(9);
        set_line(sel, ~d[i]);
        wait_ticks(1);
        set_line(sel, d[i]);
        wait_ticks(6);
      end else begin
        wait_ticks(16);
      end
    end
    if (use_par) begin
      set_line(sel, pbit);
      wait_ticks(16);
    end
    for (int k = 0; k < nstop; k++) begin
      set_line(sel, stops[k]);
      wait_ticks(16);
    end
    set_line(sel, 1'b1);
    wait_ticks(20);
  endtask

  function automatic word_t model(input logic [7:0] d,
                                  input logic [1:0] mode,
                                  input logic p,
                                  input logic [1:0] stops,
                                  input int nstop);
    word_t e;
    int ones;
    ones = $countones(d) + int'(p);
    e.d  = d;
    if (mode == 2'd1)      e.pe = (ones % 2) != 1;
    else if (mode == 2'd2) e.pe = (ones % 2) != 0;
    else                   e.pe = 1'b0;
    e.fe = !stops[0] || (nstop == 2 && !stops[1]);
    return e;
  endfunction

  function automatic logic good_par(input logic [7:0] d,
                                    input logic [1:0] mode);
    return (mode == 2'd1) ? ($countones(d) % 2 == 0)
                          : ($countones(d) % 2 == 1);
  endfunction

  task automatic expect_frame(input logic sel, input word_t e,
                              input string tag);
    word_t got;
    int n;
    for (int i = 0; i < 200; i++) begin
      n = sel ? q2.size() : q1.size();
      if (n != 0) break;
      @(negedge clk);
    end
    n = sel ? q2.size() : q1.size();
    chk({tag, "_count"}, n, 1);
    if (n > 0) begin
      got = sel ? q2.pop_front() : q1.pop_front();
      chk({tag, "_data"}, got.d, e.d);
      chk({tag, "_perr"}, got.pe, e.pe);
      chk({tag, "_ferr"}, got.fe, e.fe);
    end
    if (sel) q2.delete();
    else     q1.delete();
  endtask

  initial begin
    logic [7:0] rd;
    logic [1:0] rm;
    logic       rp;
    logic       rs;

    repeat (5) @(negedge clk);
    chk("rst_valid", v1, 0);
    chk("rst_data", d1, 0);
    chk("rst_flags", {pe1, fe1, ov1}, 0);
    chk("rst_busy", b1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ticks(4);

    pm = 2'd0;
    send(0, 8'hA5, 0, 0, 2'b11, 1, -1);
    chk("a5_busy", b1, 0);
    expect_frame(0, model(8'hA5, 2'd0, 0, 2'b11, 1), "a5");

    pm = 2'd2;
    send(0, 8'h5A, 1, 0, 2'b11, 1, -1);
    expect_frame(0, model(8'h5A, 2'd2, 0, 2'b11, 1), "even_ok");
    send(0, 8'h5A, 1, 1, 2'b11, 1, -1);
    expect_frame(0, model(8'h5A, 2'd2, 1, 2'b11, 1), "even_bad");

    pm = 2'd0;
    send(1, 8'h3C, 0, 0, 2'b11, 2, -1);
    expect_frame(1, model(8'h3C, 2'd0, 0, 2'b11, 2), "n2_ok");
    send(1, 8'h3C, 0, 0, 2'b01, 2, -1);
    expect_frame(1, model(8'h3C, 2'd0, 0, 2'b01, 2), "n2_stop2");

    rx = 1'b0;
    wait_ticks(2);
    chk("fs_busy_hi", b1, 1);
    wait_ticks(2);
    rx = 1'b1;
    wait_ticks(9);
    chk("fs_busy_lo", b1, 0);
    wait_ticks(20);
    chk("fs_valid", v1, 0);
    chk("fs_none", q1.size(), 0);

    ready = 1'b0;
    send(0, 8'h11, 0, 0, 2'b11, 1, -1);
    send(0, 8'h22, 0, 0, 2'b11, 1, -1);
    chk("ovr_valid", v1, 1);
    chk("ovr_data", d1, 8'h11);
    chk("ovr_flag", ov1, 1);
    ready = 1'b1;
    @(posedge clk); #1;
    chk("ovr_valid_clr", v1, 0);
    chk("ovr_flag_clr", ov1, 0);
    expect_frame(0, model(8'h11, 2'd0, 0, 2'b11, 1), "ovr_word");

    send(0, 8'h96, 0, 0, 2'b11, 1, 3);
    expect_frame(0, model(8'h96, 2'd0, 0, 2'b11, 1), "glitch");

    rx = 1'b0;
    wait_ticks(16 + 40);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_data", d1, 0);
    chk("mid_rst_ctl", {v1, pe1, fe1, ov1, b1}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ticks(20);
    q1.delete();
    pm = 2'd1;
    send(0, 8'hC3, 1, 1, 2'b11, 1, -1);
    expect_frame(0, model(8'hC3, 2'd1, 1, 2'b11, 1), "post_rst");

    for (int n = 0; n < 10; n++) begin
      rd = 8'($urandom);
      rm = 2'($urandom);
      rp = good_par(rd, rm) ^ ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 7) != 0);
      pm = rm;
      send(0, rd, (rm == 2'd1 || rm == 2'd2), rp, {1'b1, rs}, 1, -1);
      expect_frame(0, model(rd, rm, rp, {1'b1, rs}, 1), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised next-generation UART receiver. Oversampled by an external baud tick. Adds the following over the first-generation receiver:
- 2-flop input synchroniser
- false-start rejection
- 3-sample majority vote per bit
- runtime parity mode
- 1/2 stop bits
- parity and framing error flags
- valid/ready output holding register with overrun detection

Sits between the baud-rate generator and the RX FIFO / command interface.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9, LSB first.
STOP_BITS, 1, stop bits checked; legal 1 or 2.
OVERSAMPLE, 16, i_tick pulses per bit; even, >= 8.

Ports:
i_clock  in  1  system clock, all logic rising-edge.
i_reset_n  in  1  asynchronous, active-low reset.
i_tick  in  1  one-cycle oversample strobe, OVERSAMPLE per bit period.
i_rx  in  1  serial line, idle high; asynchronous to i_clock.
i_parity_mode  in  2  0 = none, 1 = odd, 2 = even, 3 = none; sampled once at start detection, held for the frame.
i_ready  in  1  consumer accepts o_data when o_valid & i_ready.
o_data  out  DATA_BITS  received word.
o_valid  out  1  o_data and error flags valid.
o_parity_err  out  1  parity mismatch on the held word.
o_frame_err  out  1  any checked stop bit sampled low on the held word.
o_overrun  out  1  sticky: a completed frame was dropped.
o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, synchroniser flops 1 (line idle).
- rx_s = i_rx after 2 flops (2-cycle latency). All logic uses rx_s only.
- Tick counter t runs 0..OVERSAMPLE-1 and advances only on i_tick. Samples are taken at t = M-1, M, M+1, where M = OVERSAMPLE/2.
- Bit value = majority of the three samples. The decision is made on the tick where t = M+1.
- States:
  - IDLE -> START when rx_s = 0. t cleared; i_parity_mode latched.
  - START: at decision, bit = 1 -> IDLE (false start, nothing reported); bit = 0 -> continue. At t = OVERSAMPLE-1 with i_tick, go to DATA with t = 0.
  - DATA: at each decision, shift the bit in from the MSB side (LSB first on the wire). After DATA_BITS bits, at bit end go to PARITY if parity is enabled, else STOP.
  - PARITY: at decision, compute error: odd mode requires XOR(data, p) = 1; even mode requires XOR(data, p) = 0.
  - STOP: check STOP_BITS bits; any stop decision = 0 sets the framing error. On the decision of the final stop bit, commit and go to IDLE immediately without waiting for the bit end, so the next start edge can be caught early.
- Commit happens in the cycle of the final stop decision; the holding register updates on the next edge:
  - Holding empty, or being consumed this cycle (o_valid & i_ready): load o_data and flags, o_valid = 1.
  - Else (o_valid & !i_ready): drop the new frame, retain the old word, set o_overrun.
- o_valid deasserts the cycle after a handshake unless a commit loads simultaneously; in that case it stays high with the new data.
- o_overrun clears on the next handshake with no simultaneous drop.
- A framing-error frame is still delivered with o_frame_err = 1.
- i_tick is ignored in IDLE. i_rx glitches shorter than 2 of the 3 samples are rejected.
- Async reset mid-frame: abort immediately, discard any partial word, clear the holding register.
- Counter widths: t is $clog2(OVERSAMPLE) bits; the bit counter is $clog2(DATA_BITS+1) bits; no wrap beyond terminal values.

Decomposition:
- Shared package uart_pkg:
  - state encoding (one-hot, 5 states)
  - parity-mode constants PAR_NONE / PAR_ODD / PAR_EVEN
  - helper function for majority-of-3
- Sub-module uart_rx_sampler:
  - synchroniser, tick counter, 3-sample majority
  - outputs bit value plus a one-cycle decision strobe and a bit-end strobe
- Top holds the FSM, shift register, parity/frame check and output register.

Test Plan:
- 8N1, OVERSAMPLE = 16, send 0xA5 with i_ready = 1 -> o_valid one cycle, o_data = 0xA5, both error flags 0, o_busy low after the stop decision.
- Even parity, send 0x5A (parity bit 0), then 0x5A with parity bit forced to 1 -> first word parity_err = 0, second word parity_err = 1, o_data = 0x5A both times.
- STOP_BITS = 2, second stop bit driven low for a full bit -> o_frame_err = 1, data delivered.
- 0-pulse of 4 ticks on idle line -> false start, o_valid stays 0, FSM back in IDLE before tick 16.
- i_ready = 0, send 0x11 then 0x22 -> o_data holds 0x11, o_overrun = 1; raise i_ready -> 0x11 accepted, o_overrun clears.
- Single-tick glitch at a data-bit centre -> majority vote recovers the correct value; i_reset_n pulsed low mid-DATA -> all outputs 0, next clean frame received correctly.
